// File: rtl/mem_slave_resp.sv
// Synthesizable register-file target for one cross_bar slave port: one request at a time,
// WAIT_CYCLES wait states, single-cycle ack. Optional out-of-range error response: RESP_ERR_EN.
module mem_slave_resp #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned DEPTH_LOG2  = 4,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic [ADDR_W-1:0] addr,
   input  logic              cmd,
   input  logic [DATA_W-1:0] wdata,
   output logic              ack,
   output logic [DATA_W-1:0] rdata_tr
`ifdef RESP_ERR_EN
   ,
   output logic              err
`endif
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   state_t                  state, next_state;
   logic [CNT_W-1:0]        cnt, cnt_d;
   logic                    cap;
   logic [DEPTH_LOG2-1:0]   idx_q;
   logic                    cmd_q;
   logic                    oor_q;
   logic [DATA_W-1:0]       wdata_q;
   logic [DATA_W-1:0]       mem [DEPTH];

   logic [DEPTH_LOG2-1:0]   in_idx, cur_idx;
   logic                    in_oor, cur_oor;
   logic                    cur_cmd;
   logic [DATA_W-1:0]       cur_wdata;
   logic                    fire;
   logic                    wr_fire;
   logic                    rd_fire;
   logic                    unused_addr;

   assign in_idx      = addr[DEPTH_LOG2-1:0];
   assign unused_addr = ^addr;
`ifdef RESP_ERR_EN
   assign in_oor = |addr[ADDR_W-2:DEPTH_LOG2];
`else
   assign in_oor = 1'b0;
`endif

   // With zero wait cycles the request completes on its capture edge, so use the live bus in IDLE
   assign cur_idx   = (state == S_IDLE) ? in_idx : idx_q;
   assign cur_oor   = (state == S_IDLE) ? in_oor : oor_q;
   assign cur_cmd   = (state == S_IDLE) ? cmd    : cmd_q;
   assign cur_wdata = (state == S_IDLE) ? wdata  : wdata_q;

   assign fire    = (next_state == S_ACK);
   assign wr_fire = fire && cur_cmd && !cur_oor && !reset;
   assign rd_fire = fire && !cur_cmd;

   // Next-state and wait counter
   always_comb begin
      next_state = state;
      cnt_d      = cnt;
      cap        = 1'b0;
      case (state)
         S_IDLE: begin
            if (req) begin
               cap        = 1'b1;
               cnt_d      = CNT_W'(WAIT_CYCLES);
               next_state = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) next_state = S_ACK;
         end
         S_ACK: begin
            cnt_d      = '0;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // State, holding registers and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         idx_q    <= '0;
         cmd_q    <= 1'b0;
         oor_q    <= 1'b0;
         wdata_q  <= '0;
         ack      <= 1'b0;
         rdata_tr <= '0;
`ifdef RESP_ERR_EN
         err      <= 1'b0;
`endif
      end else begin
         state <= next_state;
         cnt   <= cnt_d;
         ack   <= fire;
         if (cap) begin
            idx_q   <= in_idx;
            cmd_q   <= cmd;
            oor_q   <= in_oor;
            wdata_q <= wdata;
         end
         if (rd_fire) rdata_tr <= cur_oor ? DATA_W'(32'hDEADBEEF) : mem[cur_idx];
`ifdef RESP_ERR_EN
         err <= fire && cur_oor;
`endif
      end
   end

   // Storage is intentionally not reset
   always_ff @(posedge clk) begin
      if (wr_fire) mem[cur_idx] <= cur_wdata;
   end

endmodule

// File: tb/tb_mem_slave_resp.sv
// Scoreboard bench for mem_slave_resp: four instances (WAIT_CYCLES 0,1,2,5) share one request bus.
module tb_mem_slave_resp;

   localparam int unsigned NI = 4;
   localparam int unsigned LAT [NI] = '{0, 1, 2, 5};

   logic              clk = 1'b0;
   logic              reset;
   logic              req;
   logic [31:0]       addr;
   logic              cmd;
   logic [31:0]       wdata;
   logic [NI-1:0]     ack_v;
   logic [NI-1:0][31:0] rdata_v;
`ifdef RESP_ERR_EN
   logic [NI-1:0]     err_v;
`endif

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      mem_slave_resp #(
         .ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(4), .WAIT_CYCLES(LAT[g])
      ) u_dut (
         .clk(clk), .reset(reset), .req(req), .addr(addr), .cmd(cmd), .wdata(wdata),
         .ack(ack_v[g]), .rdata_tr(rdata_v[g])
`ifdef RESP_ERR_EN
         , .err(err_v[g])
`endif
      );
   end

   typedef struct packed {
      logic               rd;
      logic               err;
      logic [NI-1:0][31:0] data;
      logic [31:0]        e0;
   } exp_t;

   exp_t        exp_q [$];
   logic [31:0] model [NI][16];
   logic [NI-1:0] pend;
   logic [NI-1:0] prev_ack;
   int unsigned cycle;
   int unsigned n_chk;
   int unsigned n_fail;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
      end
   endtask

   // Pop the front entry once every instance has acknowledged it
   task automatic monitor();
      for (int i = 0; i < NI; i++) begin
         if (ack_v[i]) begin
            check($sformatf("ack_gap[w%0d]", LAT[i]), 32'(prev_ack[i]), 32'd0);
            if (exp_q.size() == 0 || !pend[i]) begin
               check($sformatf("spurious_ack[w%0d]", LAT[i]), 32'(ack_v[i]), 32'd0);
            end else begin
               check($sformatf("latency[w%0d]", LAT[i]), cycle, exp_q[0].e0 + LAT[i]);
               if (exp_q[0].rd)
                  check($sformatf("rdata[w%0d]", LAT[i]), rdata_v[i], exp_q[0].data[i]);
`ifdef RESP_ERR_EN
               check($sformatf("err[w%0d]", LAT[i]), 32'(err_v[i]), 32'(exp_q[0].err));
`endif
               pend[i] = 1'b0;
            end
         end
`ifdef RESP_ERR_EN
         else check($sformatf("err_idle[w%0d]", LAT[i]), 32'(err_v[i]), 32'd0);
`endif
      end
      prev_ack = ack_v;
      if (exp_q.size() != 0 && pend == '0) void'(exp_q.pop_front());
   endtask

   task automatic tick();
      @(posedge clk);
      cycle++;
      @(negedge clk);
      monitor();
   endtask

   // Build the expectation for one request and update the reference memories
   function automatic exp_t predict(input logic wr, input logic [31:0] a, input logic [31:0] d);
      exp_t        e;
      logic [3:0]  idx;
      logic        oor;
      idx = a[3:0];
`ifdef RESP_ERR_EN
      oor = |a[30:4];
`else
      oor = 1'b0;
`endif
      e.rd   = !wr;
      e.err  = oor;
      e.e0   = cycle + 1;
      e.data = '0;
      for (int i = 0; i < NI; i++) begin
         if (wr && !oor) model[i][idx] = d;
         if (!wr) e.data[i] = oor ? 32'hDEADBEEF : model[i][idx];
      end
      return e;
   endfunction

   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
      exp_q.push_back(predict(wr, a, d));
      pend  = '1;
      req   = 1'b1;
      cmd   = wr;
      addr  = a;
      wdata = d;
      tick();
      req   = 1'b0;
      addr  = $urandom;
      wdata = $urandom;
      cmd   = 1'($urandom);
   endtask

   task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] d);
      issue(wr, a, d);
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
      if (exp_q.size() != 0) begin
         check("ack_timeout", 32'(pend), 32'd0);
         exp_q.delete();
         pend = '0;
      end
      tick();
   endtask

   initial begin
      logic [31:0] old2, old3, rd;
      n_chk = 0; n_fail = 0; cycle = 0;
      pend = '0; prev_ack = '0;
      reset = 1'b1; req = 1'b0; cmd = 1'b0; addr = '0; wdata = '0;
      tick(); tick();
      for (int i = 0; i < NI; i++) begin
         check($sformatf("reset_ack[w%0d]", LAT[i]), 32'(ack_v[i]), 32'd0);
         check($sformatf("reset_rdata[w%0d]", LAT[i]), rdata_v[i], 32'd0);
      end
      reset = 1'b0;
      tick();

      txn(1'b1, 32'h0000_0003, 32'h1111_1111);
      txn(1'b0, 32'h0000_0003, 32'h0);
      txn(1'b1, 32'h0000_0005, 32'h2222_2222);
      txn(1'b0, 32'h0000_0005, 32'h0);
      txn(1'b1, 32'h8000_0009, 32'h0909_0909);
      txn(1'b0, 32'h0000_0009, 32'h0);
      txn(1'b0, 32'h0000_0003, 32'h0);
`ifndef RESP_ERR_EN
      txn(1'b1, 32'h0000_0012, 32'hA5A5_A5A5);
      txn(1'b0, 32'h0000_0002, 32'h0);
`else
      txn(1'b1, 32'h0000_0000, 32'h0000_CAFE);
      txn(1'b1, 32'h0000_0100, 32'h5555_5555);
      txn(1'b0, 32'h0000_0100, 32'h0);
      txn(1'b0, 32'h0000_0000, 32'h0);
      txn(1'b0, 32'h0000_0005, 32'h0);
`endif

      // Reset during WAIT: w0/w1 have completed, w2/w5 are still waiting
      txn(1'b1, 32'h0000_0007, 32'h7777_7777);
      old2 = model[2][7];
      old3 = model[3][7];
      issue(1'b1, 32'h0000_0007, 32'h3333_3333);
      tick();
      reset = 1'b1;
      #1;
      check("inflight_at_reset", 32'(pend), 32'(4'b1100));
      for (int i = 0; i < NI; i++) begin
         check($sformatf("midreset_ack[w%0d]", LAT[i]), 32'(ack_v[i]), 32'd0);
         check($sformatf("midreset_rdata[w%0d]", LAT[i]), rdata_v[i], 32'd0);
      end
      exp_q.delete();
      pend = '0;
      model[2][7] = old2;
      model[3][7] = old3;
      tick(); tick();
      reset = 1'b0;
      tick();
      txn(1'b0, 32'h0000_0007, 32'h0);

      for (int k = 0; k < 6; k++) begin
         rd = $urandom;
         txn(1'b1, 32'(8 + k), rd);
      end
      for (int k = 0; k < 6; k++) txn(1'b0, 32'(8 + k), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
